la_capture_core: RTL and testbench

- Parametrised in-fabric logic-analyser capture engine for debugging video timing (VS/HS/DE, reset) without the vendor JTAG analyser.
- Samples a DATA_W-bit probe bus every sys_clk into a circular buffer.
- Supports programmable pre-trigger depth, masked level or edge trigger, abort, and a registered post-capture readout port for a UART/register bridge.

---
 rtl/la_capture_core.sv | 108 ++++++++++
 tb/tb_la_capture_core.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/la_capture_core.sv
// la_capture_core: circular-buffer logic-analyser capture with pre-trigger depth,
// masked level/edge trigger, abort and a registered readout port.
module la_capture_core #(
  parameter int DATA_W = 4,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [2:0]        state_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic              done_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, p_q, p_d, trig_addr_q, trig_addr_d, rd_phys;
  logic [DATA_W-1:0] mask_q, mask_d, value_q, value_d, rd_data_q, rd_data_d;
  logic edge_q, edge_d, prev_match_q, prev_match_d, rd_valid_q, rd_valid_d;
  logic match, fire, arm_ok, writing;
  // Trigger compares against the configuration latched at arm, not the live inputs
  assign match = ((data_i ^ value_q) & mask_q) == '0;
  assign fire = edge_q ? match && !prev_match_q : match;
  assign arm_ok = arm && !abort && (state_q == IDLE || state_q == DONE);
  assign writing = state_q == PRE || state_q == WAIT || state_q == POST;
  // In DONE the write pointer sits on the oldest sample
  assign rd_phys = wr_ptr_q + rd_addr;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = writing ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cnt_d = state_q == WAIT ? '0 : cnt_q + 1'b1;
    p_d = p_q;
    mask_d = mask_q;
    value_d = value_q;
    edge_d = edge_q;
    trig_addr_d = trig_addr_q;
    prev_match_d = match;
    rd_valid_d = rd_en && state_q == DONE;
    rd_data_d = rd_valid_d ? mem[rd_phys] : rd_data_q;
    if (abort) state_d = IDLE;
    else if (arm_ok) begin
      state_d = pretrig_len == '0 ? WAIT : PRE;
      wr_ptr_d = '0;
      cnt_d = '0;
      p_d = pretrig_len;
      mask_d = trig_mask;
      value_d = trig_value;
      edge_d = trig_edge;
      prev_match_d = 1'b1;
    end else begin
      case (state_q)
        PRE: state_d = cnt_q == p_q - 1'b1 ? WAIT : PRE;
        WAIT: if (fire) begin
          trig_addr_d = wr_ptr_q;
          state_d = p_q == '1 ? DONE : POST;
        end
        POST: state_d = cnt_q == ~p_q - 1'b1 ? DONE : POST;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      p_q <= '0;
      mask_q <= '0;
      value_q <= '0;
      edge_q <= 1'b0;
      trig_addr_q <= '0;
      prev_match_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      mask_q <= mask_d;
      value_q <= value_d;
      edge_q <= edge_d;
      trig_addr_q <= trig_addr_d;
      prev_match_q <= prev_match_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (writing) mem[wr_ptr_q] <= data_i;
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign state_o = state_q;
  assign trig_addr_o = trig_addr_q;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: directed checks of capture, trigger, abort and readout at DEPTH=16.
module tb_la_capture_core;
  localparam int DW = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [DW-1:0] data_i = '0, trig_mask = '0, trig_value = '0, rd_data;
  logic arm = 1'b0, abort = 1'b0, trig_edge = 1'b0, rd_en = 1'b0, rd_valid, done_o;
  logic [AW-1:0] pretrig_len = '0, rd_addr = '0, trig_addr_o;
  logic [2:0] state_o;
  int n_cmp = 0;
  int n_err = 0;
  bit auto_cnt = 1'b0;
  always #5 sys_clk = ~sys_clk;
  la_capture_core #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_i(data_i), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
    .pretrig_len(pretrig_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .state_o(state_o), .trig_addr_o(trig_addr_o), .done_o(done_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      if (auto_cnt) data_i = data_i + 1'b1;
    end
  endtask
  task automatic do_arm(input logic [AW-1:0] p, input logic [DW-1:0] m, input logic [DW-1:0] v, input logic e);
    pretrig_len = p;
    trig_mask = m;
    trig_value = v;
    trig_edge = e;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    data_i = '0;
    auto_cnt = 1'b1;
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    rd_en = 1'b1;
    rd_addr = a;
    cyc();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 1);
    chk(tag, 32'(rd_data), 32'(exp));
    cyc();
    chk({tag, "_pulse"}, 32'(rd_valid), 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      data_i = 4'($urandom);
      arm = 1'($urandom);
      abort = 1'($urandom);
      trig_mask = 4'($urandom);
      trig_value = 4'($urandom);
      trig_edge = 1'($urandom);
      pretrig_len = 4'($urandom);
      rd_en = 1'($urandom);
      rd_addr = 4'($urandom);
      cyc();
    end
    sys_rst = 1'b0;
    {data_i, arm, abort, trig_mask, trig_value, trig_edge, pretrig_len, rd_en, rd_addr} = '0;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_trig_addr", 32'(trig_addr_o), 0);
    // level mode, P=4
    do_arm(4'd4, 4'b0001, 4'b0001, 1'b0);
    chk("lvl_pre", 32'(state_o), 1);
    cyc(3);
    chk("lvl_pre3", 32'(state_o), 1);
    cyc();
    chk("lvl_wait", 32'(state_o), 2);
    cyc();
    chk("lvl_miss4", 32'(state_o), 2);
    cyc();
    chk("lvl_post", 32'(state_o), 3);
    chk("lvl_trig_addr", 32'(trig_addr_o), 5);
    cyc(10);
    chk("lvl_post10", 32'(done_o), 0);
    cyc();
    chk("lvl_done11", 32'(done_o), 1);
    chk("lvl_state_done", 32'(state_o), 4);
    auto_cnt = 1'b0;
    rd(4'd0, 4'd1, "lvl_rd0");
    rd(4'd4, 4'd5, "lvl_rd4");
    rd(4'd15, 4'd0, "lvl_rd15");
    // edge mode from DONE, P=2
    data_i = 4'hF;
    pretrig_len = 4'd2;
    trig_mask = 4'b1000;
    trig_value = 4'b1000;
    trig_edge = 1'b1;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    chk("edg_pre", 32'(state_o), 1);
    cyc(5);
    chk("edg_held_high", 32'(state_o), 2);
    data_i = 4'h0;
    cyc(2);
    chk("edg_low", 32'(state_o), 2);
    data_i = 4'h8;
    cyc();
    chk("edg_fire", 32'(state_o), 3);
    chk("edg_trig_addr", 32'(trig_addr_o), 7);
    // abort mid-POST
    cyc(3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abt_state", 32'(state_o), 0);
    chk("abt_done", 32'(done_o), 0);
    chk("abt_trig_hold", 32'(trig_addr_o), 7);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("abt_rd_valid", 32'(rd_valid), 0);
    arm = 1'b1;
    abort = 1'b1;
    cyc();
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_idle", 32'(state_o), 0);
    // P=0, mask=0: fires on first sample
    do_arm(4'd0, 4'd0, 4'd0, 1'b0);
    chk("p0_wait", 32'(state_o), 2);
    cyc();
    chk("p0_post", 32'(state_o), 3);
    chk("p0_trig_addr", 32'(trig_addr_o), 0);
    cyc(14);
    chk("p0_post14", 32'(state_o), 3);
    cyc();
    chk("p0_done", 32'(done_o), 1);
    auto_cnt = 1'b0;
    rd(4'd0, 4'd0, "p0_rd0");
    rd(4'd9, 4'd9, "p0_rd9");
    // P=DEPTH-1: DONE straight from WAIT
    do_arm(4'd15, 4'd0, 4'd0, 1'b0);
    chk("p15_pre", 32'(state_o), 1);
    cyc(14);
    chk("p15_pre14", 32'(state_o), 1);
    cyc();
    chk("p15_wait", 32'(state_o), 2);
    cyc();
    chk("p15_done", 32'(state_o), 4);
    chk("p15_trig_addr", 32'(trig_addr_o), 15);
    auto_cnt = 1'b0;
    rd(4'd15, 4'd15, "p15_rd15");
    rd(4'd0, 4'd0, "p15_rd0");
    // arm ignored during WAIT
    do_arm(4'd2, 4'hF, 4'd9, 1'b0);
    cyc(2);
    chk("aw_wait", 32'(state_o), 2);
    cyc(3);
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    chk("aw_ignored", 32'(state_o), 2);
    cyc(3);
    chk("aw_wait9", 32'(state_o), 2);
    cyc();
    chk("aw_post", 32'(state_o), 3);
    chk("aw_trig_addr", 32'(trig_addr_o), 9);
    cyc(12);
    chk("aw_post12", 32'(state_o), 3);
    cyc();
    chk("aw_done", 32'(done_o), 1);
    auto_cnt = 1'b0;
    rd(4'd0, 4'd7, "aw_rd0");
    rd(4'd2, 4'd9, "aw_rd2");
    do_arm(4'd3, 4'd0, 4'd0, 1'b0);
    chk("rearm_pre", 32'(state_o), 1);
    chk("rearm_done", 32'(done_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
